boot_mem: RTL

//   Parametrised boot memory. The low ROM_WORDS words are a fixed boot program; the rest of the
//   2**AW words are writable scratch RAM. Sits on the CPU instruction/data bus at the boot window.
//   The RAM is cleared by a hardware walk after reset. Reads are registered with a valid strobe.

---
 rtl/boot_mem.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/boot_mem.sv
// -----------------------------------------------------------------------------
// boot_mem
//   Boot-window memory for the CPU instruction/data bus.
//   - Words 0..ROM_WORDS-1 form a fixed boot program taken from ROM_INIT.
//     They are plain constants and no flops hold them.
//   - Words ROM_WORDS..2**AW-1 are scratch RAM. After reset, a hardware walk
//     clears this RAM one word per cycle. busy is high while the walk runs.
//   - Reads are registered. dout updates one cycle after a read is accepted,
//     and rd_valid pulses for that cycle.
//   - A rejected access produces a one-cycle err pulse on the next cycle.
//     Rejected accesses are any access during the clear, a write to ROM, and
//     any write while locked.
//
//   Optional feature macro: BOOT_MEM_LOCK_EN
//     When it is defined, writing all-ones to the top word (2**AW-1) sets the
//     locked flag and leaves that word unchanged. While locked, every write is
//     rejected. Only rst clears the flag.
//     When it is undefined, locked is tied 0 and that write is an ordinary
//     RAM write.
//
// Ports
//   clk       in   1   system clock, posedge
//   rst       in   1   synchronous active-high reset, highest priority
//   cs        in   1   chip select, access request
//   we        in   1   1 = write, 0 = read
//   addr      in   AW  word address; the full 2**AW range is decoded
//   din       in   DW  write data
//   dout      out  DW  registered read data, holds between reads
//   rd_valid  out  1   dout was updated by the read accepted last cycle
//   busy      out  1   post-reset RAM clear in progress
//   err       out  1   access rejected last cycle
//   locked    out  1   RAM write lock status
//
// Bus handshake: there is no back-pressure. An access is offered by cs=1 in a
// cycle and is either accepted or rejected at that clock edge. The outcome
// appears the next cycle: rd_valid=1 for an accepted read, err=1 for a
// rejected access, and neither for an accepted write or an idle cycle.
// -----------------------------------------------------------------------------
module boot_mem #(
    parameter int DW        = 16,
    parameter int AW        = 5,
    parameter int ROM_WORDS = 8,
    parameter logic [ROM_WORDS*DW-1:0] ROM_INIT = {
        16'h0000, 16'h4000, 16'h3008, 16'hF400,
        16'h1007, 16'hF800, 16'h4000, 16'hF200
    }
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          rd_valid,
    output logic          busy,
    output logic          err,
    output logic          locked
);

    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW-1:0] ROM_BASE = AW'(ROM_WORDS);  // first RAM word
    localparam logic [AW-1:0] TOP_ADDR = AW'(DEPTH - 1);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    // The FSM state is kept as a plainly named signal so checkers can bind to it.
    logic [0:0]    state;
    logic [AW-1:0] clr_ptr;
    logic [DW-1:0] ram [ROM_WORDS:DEPTH-1];  // RAM words only, no ROM storage

    logic          idle;
    logic          in_rom;
    logic          lock_hit;
    logic          rd_acc;
    logic          wr_acc;
    logic          reject;
    logic [DW-1:0] rd_word;

    assign idle   = (state == IDLE);
    assign busy   = ~idle;
    assign in_rom = (addr < ROM_BASE);

`ifdef BOOT_MEM_LOCK_EN
    logic lock_q;

    // This is the lock command. It is a request, not a data write, so the
    // top word keeps its value.
    assign lock_hit = idle && cs && we && !lock_q &&
                      (addr == TOP_ADDR) && (din == {DW{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else if (lock_hit) begin
            lock_q <= 1'b1;
        end
    end

    assign locked = lock_q;
`else
    assign lock_hit = 1'b0;
    assign locked   = 1'b0;
`endif

    assign rd_acc = idle && cs && !we;
    assign wr_acc = idle && cs && we && !in_rom && !locked && !lock_hit;
    // Every access is rejected during the clear. In IDLE, a write is rejected
    // when it targets ROM or when the lock is set.
    assign reject = cs && (!idle || (we && (in_rom || locked)));

    // ROM words come straight from the parameter.
    always_comb begin
        rd_word = '0;
        if (in_rom) begin
            for (int i = 0; i < ROM_WORDS; i++) begin
                if (addr == AW'(i)) begin
                    rd_word = ROM_INIT[i*DW +: DW];
                end
            end
        end else begin
            rd_word = ram[addr];
        end
    end

    // RAM array has no reset. The post-reset walk zeroes it instead.
    // The clear and a bus write can never collide, because writes are only
    // accepted in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!idle) begin
                ram[clr_ptr] <= '0;
            end else if (wr_acc) begin
                ram[addr] <= din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_ptr  <= ROM_BASE;
            dout     <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            err      <= reject;
            if (rd_acc) begin
                dout <= rd_word;
            end
            if (!idle) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_ptr == TOP_ADDR) begin
                    state <= IDLE;
                end
            end
        end
    end

endmodule
